// File: rtl/addr_bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer and the address ALU:
// FSM encoding, segment codes and address-ALU OP codes.
package addr_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } bus_state_t;

  localparam logic [1:0] SEG_ES = 2'd0;
  localparam logic [1:0] SEG_CS = 2'd1;
  localparam logic [1:0] SEG_SS = 2'd2;
  localparam logic [1:0] SEG_DS = 2'd3;

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_MODE1 = 3'd1;
  localparam logic [2:0] OP_MODE2 = 3'd2;
  localparam logic [2:0] OP_MODE3 = 3'd3;
  localparam logic [2:0] OP_MODE4 = 3'd4;
  localparam logic [2:0] OP_MODE5 = 3'd5;

  // Modes outside 1..5 have no ALU meaning and fall back to mode 2.
  function automatic logic [2:0] norm_mode(input logic [2:0] mode);
    if (mode == 3'd0 || mode > OP_MODE5) return OP_MODE2;
    return mode;
  endfunction

endpackage

// File: rtl/addr_bus_sequencer_arbiter.sv
// Fetch/EU arbiter: EU has priority, but a pending fetch wins once
// STARVE_MAX consecutive EU grants have gone by while it waited.
module fetch_eu_arbiter #(
  parameter int STARVE_MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic fetch_req,
  input  logic eu_req,
  output logic grant_fetch,
  output logic grant_eu
);

  localparam int CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = fetch_req && (starve_cnt >= CW'(STARVE_MAX));

  always_comb begin
    grant_eu    = grant_en && eu_req && !starved;
    grant_fetch = grant_en && fetch_req && !grant_eu;
  end

  // An EU grant with no fetch waiting breaks the consecutive run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_fetch) begin
      starve_cnt <= '0;
    end else if (grant_eu) begin
      if (!fetch_req) starve_cnt <= '0;
      else if (starve_cnt < CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/addr_bus_sequencer.sv
// Bus sequencer: arbitrates instruction fetch against EU data accesses,
// drives the address ALU, and runs one memory access at a time.
module addr_bus_sequencer
  import addr_bus_sequencer_pkg::*;
#(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  output logic        fetch_ack,
  output logic [15:0] fetch_data,
  output logic        ip_inc,
  input  logic        eu_req,
  input  logic        eu_we,
  input  logic [2:0]  eu_mode,
  input  logic [1:0]  eu_seg,
  input  logic [15:0] eu_wdata,
  output logic        eu_ack,
  output logic [15:0] eu_rdata,
  output logic        err,
  output logic [2:0]  alu_op,
  output logic [1:0]  seg_sel,
  input  logic [19:0] alu_dir,
  output logic [19:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int WW = $clog2(TIMEOUT + 1);

  bus_state_t    state, state_next;
  logic          grant_fetch, grant_eu;
  logic          gnt_fetch, gnt_we;
  logic          timed_out;
  logic [WW-1:0] wait_cnt;
  logic          wait_expired;

  fetch_eu_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .grant_en    (state == ST_IDLE),
    .fetch_req   (fetch_req),
    .eu_req      (eu_req),
    .grant_fetch (grant_fetch),
    .grant_eu    (grant_eu)
  );

  // This ACCESS cycle is the TIMEOUT-th one without mem_ready.
  assign wait_expired = !mem_ready && (wait_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    fetch_ack  = 1'b0;
    eu_ack     = 1'b0;
    err        = 1'b0;
    ip_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_fetch || grant_eu) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_rd = !gnt_we;
        mem_wr = gnt_we;
        if (mem_ready || wait_expired) state_next = ST_DONE;
      end
      ST_DONE: begin
        fetch_ack  = gnt_fetch;
        eu_ack     = !gnt_fetch;
        err        = timed_out;
        ip_inc     = gnt_fetch && !timed_out;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // alu_op/seg_sel are loaded at the grant edge so they are stable
  // throughout ADDR, and simply hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_fetch  <= 1'b0;
      gnt_we     <= 1'b0;
      timed_out  <= 1'b0;
      wait_cnt   <= '0;
      alu_op     <= '0;
      seg_sel    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fetch_data <= '0;
      eu_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fetch) begin
            gnt_fetch <= 1'b1;
            gnt_we    <= 1'b0;
            alu_op    <= OP_FETCH;
            seg_sel   <= SEG_CS;
            timed_out <= 1'b0;
            wait_cnt  <= '0;
          end else if (grant_eu) begin
            gnt_fetch <= 1'b0;
            gnt_we    <= eu_we;
            alu_op    <= norm_mode(eu_mode);
            seg_sel   <= eu_seg;
            mem_wdata <= eu_wdata;
            timed_out <= 1'b0;
            wait_cnt  <= '0;
          end
        end
        ST_ADDR: begin
          mem_addr <= alu_dir;
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            if (gnt_fetch)    fetch_data <= mem_rdata;
            else if (!gnt_we) eu_rdata   <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
            if (wait_expired) timed_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_bus_sequencer.sv
// Self-checking bench for addr_bus_sequencer: directed scenarios plus
// randomized transactions against a transaction-level reference model.
module tb_addr_bus_sequencer;

  localparam int TIMEOUT    = 15;
  localparam int STARVE_MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, eu_req, eu_we, mem_ready;
  logic [2:0]  eu_mode;
  logic [1:0]  eu_seg;
  logic [15:0] eu_wdata, mem_rdata;
  logic        fetch_ack, ip_inc, eu_ack, err, mem_rd, mem_wr;
  logic [15:0] fetch_data, eu_rdata, mem_wdata;
  logic [2:0]  alu_op;
  logic [1:0]  seg_sel;
  logic [19:0] alu_dir, mem_addr;
  logic [14:0] base;

  int   n_pass   = 0;
  int   n_checks = 0;
  int   starve   = 0;
  logic last_fetch_won;

  addr_bus_sequencer #(
    .TIMEOUT    (TIMEOUT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .ip_inc     (ip_inc),
    .eu_req     (eu_req),
    .eu_we      (eu_we),
    .eu_mode    (eu_mode),
    .eu_seg     (eu_seg),
    .eu_wdata   (eu_wdata),
    .eu_ack     (eu_ack),
    .eu_rdata   (eu_rdata),
    .err        (err),
    .alu_op     (alu_op),
    .seg_sel    (seg_sel),
    .alu_dir    (alu_dir),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  // Address ALU stand-in: the address encodes segment, op and a per-transaction base.
  assign alu_dir = {seg_sel, alu_op, base};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic quiet(input string tag);
    check(tag, {26'd0, mem_rd, mem_wr, fetch_ack, eu_ack, err, ip_inc}, 32'd0);
  endtask

  // One complete transaction, entered and left in an IDLE cycle.
  task automatic txn(input logic f, input logic e, input logic we,
                     input logic [2:0] mode, input logic [1:0] seg,
                     input logic [15:0] wd, input int waits,
                     input logic [15:0] rdata, input logic hold);
    logic       win_fetch, to;
    logic [2:0] x_op;
    logic [1:0] x_seg;
    int         n_acc;
    fetch_req = f;  eu_req = e;  eu_we = we;  eu_mode = mode;
    eu_seg = seg;   eu_wdata = wd;  mem_ready = 1'b0;
    base = 15'($urandom);
    win_fetch = f && (!e || starve >= STARVE_MAX);
    if (win_fetch) starve = 0;
    else if (f)    starve = starve + 1;
    else           starve = 0;
    x_op  = win_fetch ? 3'd0 : ((mode >= 3'd1 && mode <= 3'd5) ? mode : 3'd2);
    x_seg = win_fetch ? 2'd1 : seg;
    to    = (waits >= TIMEOUT);
    n_acc = to ? TIMEOUT : waits + 1;
    @(posedge clk); #1;
    eu_we = 1'($urandom);  eu_mode = 3'($urandom);
    eu_seg = 2'($urandom); eu_wdata = 16'($urandom);
    check("addr_alu_op", alu_op, x_op);
    check("addr_seg_sel", seg_sel, x_seg);
    quiet("addr_quiet");
    for (int k = 0; k < n_acc; k++) begin
      @(posedge clk); #1;
      check("acc_strobe", {mem_rd, mem_wr}, (win_fetch || !we) ? 2'b10 : 2'b01);
      check("acc_mem_addr", mem_addr, {x_seg, x_op, base});
      check("acc_hold_op_seg", {alu_op, seg_sel}, {x_op, x_seg});
      check("acc_no_ack", {fetch_ack, eu_ack, err, ip_inc}, 4'd0);
      if (!win_fetch && we) check("acc_mem_wdata", mem_wdata, wd);
      mem_ready = (k == waits);
      mem_rdata = (k == waits) ? rdata : 16'($urandom);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    last_fetch_won = fetch_ack;
    check("done_acks", {fetch_ack, eu_ack}, {win_fetch, !win_fetch});
    check("done_err", err, to);
    check("done_ip_inc", ip_inc, win_fetch && !to);
    check("done_strobes", {mem_rd, mem_wr}, 2'b00);
    if (!to && win_fetch)        check("fetch_data", fetch_data, rdata);
    if (!to && !win_fetch && !we) check("eu_rdata", eu_rdata, rdata);
    if (!hold) begin
      fetch_req = 1'b0;
      eu_req    = 1'b0;
    end
    @(posedge clk); #1;
    quiet("idle_quiet");
  endtask

  initial begin
    logic [5:0] order;
    rst = 1'b1;  fetch_req = 1'b0;  eu_req = 1'b0;  eu_we = 1'b0;
    eu_mode = 3'd0;  eu_seg = 2'd0;  eu_wdata = 16'd0;
    mem_rdata = 16'd0;  mem_ready = 1'b0;  base = 15'd0;
    repeat (2) @(posedge clk);
    #1;
    quiet("reset_strobes_acks");
    check("reset_op_seg", {alu_op, seg_sel}, 5'd0);
    check("reset_addr_wdata", {mem_addr, mem_wdata}, 36'd0);
    check("reset_data", {fetch_data, eu_rdata}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch only, memory immediately ready.
    txn(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 0, 16'hBEEF, 1'b0);
    // EU write, mode 5, DS, four wait cycles.
    txn(1'b0, 1'b1, 1'b1, 3'd5, 2'd3, 16'h1234, 4, 16'h0000, 1'b0);

    // Both requests held: EU, EU, fetch, EU, EU, fetch.
    for (int i = 0; i < 6; i++) begin
      txn(1'b1, 1'b1, 1'b0, 3'd3, 2'd2, 16'h5A5A, 0, 16'($urandom), 1'b1);
      order[i] = last_fetch_won;
    end
    check("starve_order", order, 6'b100100);
    fetch_req = 1'b0;
    eu_req    = 1'b0;

    // Timeouts: fetch (no ip_inc) and EU read.
    txn(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, TIMEOUT + 3, 16'h1111, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 3'd1, 2'd0, 16'h0000, TIMEOUT, 16'h2222, 1'b0);
    // Longest successful wait, then the illegal-mode fallbacks.
    txn(1'b0, 1'b1, 1'b0, 3'd4, 2'd1, 16'h0000, TIMEOUT - 1, 16'hC0DE, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 3'd7, 2'd2, 16'h0000, 1, 16'hA001, 1'b0);
    txn(1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 16'h7777, 0, 16'h0000, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 3'd6, 2'd3, 16'h0000, 2, 16'hA006, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic f, e;
      f = 1'($urandom);
      e = 1'($urandom);
      if (!f && !e) e = 1'b1;
      txn(f, e, 1'($urandom), 3'($urandom), 2'($urandom), 16'($urandom),
          int'($urandom_range(0, TIMEOUT + 2)), 16'($urandom), 1'($urandom));
    end
    fetch_req = 1'b0;
    eu_req    = 1'b0;
    @(posedge clk); #1;
    starve = 0;

    // Reset in the middle of an EU read access.
    eu_req = 1'b1;  eu_we = 1'b0;  eu_mode = 3'd3;  eu_seg = 2'd2;
    base = 15'h1ABC;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_in_access", mem_rd, 1'b1);
    #2 rst = 1'b1;
    #1;
    quiet("rst_async_strobes_acks");
    check("rst_async_op_seg", {alu_op, seg_sel}, 5'd0);
    check("rst_async_addr_wdata", {mem_addr, mem_wdata}, 36'd0);
    check("rst_async_data", {fetch_data, eu_rdata}, 32'd0);
    eu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      quiet("post_reset_idle");
    end
    txn(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 1, 16'h4321, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addr_bus_sequencer.md
ADDR_BUS_SEQUENCER -- requirements
Module: addr_bus_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum ACCESS cycles waited for mem_ready before aborting.
REQ-002 SHALL have parameter STARVE_MAX, default 2, meaning the consecutive EU grants allowed while a fetch is pending.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 fetch_req  in  1  instruction-fetch request, level, held until fetch_ack.
REQ-006 fetch_ack  out  1  one-cycle pulse; fetch_data valid in the same cycle.
REQ-007 fetch_data  out  16  fetched word.
REQ-008 ip_inc  out  1  one-cycle pulse coincident with a successful fetch_ack (IP += 2).
REQ-009 eu_req  in  1  execution-unit data request, level, held until eu_ack.
REQ-010 eu_we  in  1  1 = write, 0 = read; sampled at grant.
REQ-011 eu_mode  in  3  addressing mode 1..5 for the address ALU; sampled at grant.
REQ-012 eu_seg  in  2  segment select (0 ES, 1 CS, 2 SS, 3 DS); sampled at grant.
REQ-013 eu_wdata  in  16  write data; sampled at grant.
REQ-014 eu_ack  out  1  one-cycle pulse; eu_rdata valid in the same cycle for reads.
REQ-015 eu_rdata  out  16  read word.
REQ-016 err  out  1  one-cycle pulse, coincident with the ack, when the access timed out.
REQ-017 alu_op  out  3  OP driven to the address ALU.
REQ-018 seg_sel  out  2  segment register select driven to the register file.
REQ-019 alu_dir  in  20  20-bit address returned by the address ALU (combinational).
REQ-020 mem_addr  out  20  memory address, latched.
REQ-021 mem_rd / mem_wr  out  1 each  memory strobes; never both high.
REQ-022 mem_wdata  out  16  write data.
REQ-023 mem_rdata  in  16  read data.
REQ-024 mem_ready  in  1  memory completion, sampled every ACCESS cycle.

Function
REQ-025 SHALL implement a four-state FSM with states IDLE, ADDR, ACCESS and DONE.
REQ-026 IDLE, no request pending: SHALL remain in IDLE.
REQ-027 IDLE, any request pending: SHALL grant one requester, latch its attributes, and move to ADDR.
REQ-028 Arbitration: EU SHALL win over fetch.
REQ-029 Starvation guard: fetch SHALL win when STARVE_MAX consecutive EU grants occurred while fetch_req was high.
REQ-030 The consecutive-grant counter SHALL clear on every fetch grant.
REQ-031 ADDR: alu_op SHALL be 0 for a fetch and the latched eu_mode for an EU request.
REQ-032 ADDR: seg_sel SHALL be 1 (CS) for a fetch and the latched eu_seg for an EU request.
REQ-033 ADDR: alu_dir SHALL be captured into mem_addr, and the FSM SHALL move to ACCESS.
REQ-034 An eu_mode of 0, 6 or 7 SHALL be forced to mode 2.
REQ-035 ACCESS: mem_rd or mem_wr SHALL be held high each cycle.
REQ-036 ACCESS: the wait counter SHALL increment each cycle without mem_ready.
REQ-037 ACCESS: mem_ready high SHALL capture mem_rdata (on a read) and move to DONE.
REQ-038 ACCESS: a wait count reaching TIMEOUT SHALL drop the strobe, set a timeout flag and move to DONE.
REQ-039 DONE: SHALL pulse the granted requester's ack and return to IDLE.
REQ-040 DONE: SHALL pulse ip_inc with a successful fetch ack only, never on a timeout.
REQ-041 DONE: SHALL pulse err on a timeout.
REQ-042 Latency: with mem_ready already high, the ack SHALL occur 3 cycles after the grant edge (ADDR, ACCESS, DONE).
REQ-043 Requests arriving outside IDLE SHALL wait; a new grant SHALL occur no earlier than the cycle after DONE.
REQ-044 Outside ADDR, alu_op and seg_sel SHALL hold their last value.
REQ-045 Outside ACCESS, mem_rd and mem_wr SHALL be low.

Reset
REQ-046 rst SHALL force IDLE immediately, asynchronously, including in the middle of an access.
REQ-047 rst SHALL drive every output to zero, including strobes, acks, err, ip_inc, mem_addr, data outputs, alu_op and seg_sel.
REQ-048 rst SHALL clear the starvation and wait counters.
REQ-049 No ack SHALL be issued for an access aborted by reset.

Structure
REQ-050 State encodings, segment codes (ES/CS/SS/DS) and ALU OP codes SHALL reside in a shared package used by this block and the address ALU.
REQ-051 The arbiter, including the starvation counter, SHALL be a single sub-module named fetch_eu_arbiter.

Verification
REQ-052 Fetch only, mem_ready tied high: alu_op=0 and seg_sel=1 in ADDR; fetch_ack and ip_inc 3 cycles after the grant; fetch_data = mem_rdata (e.g. 16'hBEEF).
REQ-053 EU write, mode 5, seg 3, wdata 16'h1234, mem_ready after 4 wait cycles: mem_wr high 5 cycles, mem_wdata=16'h1234, mem_addr = alu_dir, one eu_ack, no err.
REQ-054 fetch_req and eu_req held high continuously: grant order EU, EU, fetch, EU, EU, fetch.
REQ-055 mem_ready held low: strobe drops after 15 ACCESS cycles; ack and err pulse together; no ip_inc for a fetch.
REQ-056 rst asserted mid-ACCESS: all outputs zero the same cycle; after release, an idle bus and no spurious ack.
REQ-057 eu_mode=7: alu_op=2 in ADDR.
